// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin sharing of one host I/O command/response channel between requesters.
// Issuer IDs of accepted commands are queued in order so responses return to their owner.
module bp_io_cmd_arbiter #(
   parameter int num_req_p         = 2,
   parameter int msg_width_p       = 256,
   parameter int max_outstanding_p = 4
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [num_req_p*msg_width_p-1:0]     req_cmd_i,
   input  logic [num_req_p-1:0]                 req_cmd_v_i,
   output logic [num_req_p-1:0]                 req_cmd_ready_o,
   output logic [msg_width_p-1:0]               cmd_o,
   output logic                                 cmd_v_o,
   input  logic                                 cmd_ready_i,
   input  logic [msg_width_p-1:0]               resp_i,
   input  logic                                 resp_v_i,
   output logic                                 resp_ready_o,
   output logic [msg_width_p-1:0]               req_resp_o,
   output logic [num_req_p-1:0]                 req_resp_v_o,
   input  logic [num_req_p-1:0]                 req_resp_ready_i,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                 err_o
);

   localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w = $clog2(max_outstanding_p+1);

   logic [id_w-1:0]      rr_ptr, grant, head, g_hi, g_lo;
   logic [id_w-1:0]      id_mem [max_outstanding_p];
   logic [ptr_w:0]       wr_ptr, rd_ptr;
   logic [num_req_p-1:0] eligible;
   logic                 full, empty, any_elig, found_hi, found_lo;
   logic                 cmd_fire, resp_fire, err_q;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                     (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
   assign eligible = full ? '0 : req_cmd_v_i;
   assign any_elig = |eligible;
   assign head     = id_mem[rd_ptr[ptr_w-1:0]];

   // First eligible at or above the pointer wins; otherwise wrap to the lowest eligible.
   always_comb begin
      g_hi     = '0;
      g_lo     = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int j = 0; j < num_req_p; j++) begin
         if (eligible[j] && !found_lo) begin
            g_lo     = id_w'(j);
            found_lo = 1'b1;
         end
         if (eligible[j] && !found_hi && (j >= int'(rr_ptr))) begin
            g_hi     = id_w'(j);
            found_hi = 1'b1;
         end
      end
      grant = found_hi ? g_hi : g_lo;
   end

   assign cmd_o     = req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
   assign cmd_v_o   = reset_n_i & any_elig;
   assign cmd_fire  = cmd_v_o & cmd_ready_i;

   // An empty FIFO still accepts a response so a stray one cannot wedge the link.
   assign resp_ready_o = reset_n_i & (empty ? resp_v_i : req_resp_ready_i[head]);
   assign resp_fire    = resp_v_i & resp_ready_o & ~empty;
   assign req_resp_o   = resp_i;

   always_comb begin
      req_cmd_ready_o = '0;
      req_resp_v_o    = '0;
      for (int j = 0; j < num_req_p; j++) begin
         if (grant == id_w'(j))
            req_cmd_ready_o[j] = reset_n_i & any_elig & cmd_ready_i;
         if (head == id_w'(j))
            req_resp_v_o[j] = reset_n_i & resp_v_i & ~empty;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         err_q  <= 1'b0;
      end else begin
         if (cmd_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= (grant == id_w'(num_req_p-1)) ? '0 : grant + 1'b1;
         end
         if (resp_fire)
            rd_ptr <= rd_ptr + 1'b1;
         if (resp_v_i && empty)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (cmd_fire)
         id_mem[wr_ptr[ptr_w-1:0]] <= grant;
   end

   assign outstanding_o = cnt_w'(wr_ptr - rd_ptr);
   assign err_o         = err_q;

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Bench for bp_io_cmd_arbiter: idle-state vector table plus scoreboarded multi-cycle sequences.
module tb_bp_io_cmd_arbiter;

   localparam int N = 2;
   localparam int W = 16;
   localparam int M = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N*W-1:0] req_cmd;
   logic [N-1:0]  req_cmd_v;
   logic [N-1:0]  req_cmd_ready;
   logic [W-1:0]  cmd;
   logic          cmd_v;
   logic          cmd_ready;
   logic [W-1:0]  resp;
   logic          resp_v;
   logic          resp_ready;
   logic [W-1:0]  req_resp;
   logic [N-1:0]  req_resp_v;
   logic [N-1:0]  req_resp_ready;
   logic [2:0]    outstanding;
   logic          err;

   bp_io_cmd_arbiter #(.num_req_p(N), .msg_width_p(W), .max_outstanding_p(M)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .req_cmd_i(req_cmd), .req_cmd_v_i(req_cmd_v), .req_cmd_ready_o(req_cmd_ready),
      .cmd_o(cmd), .cmd_v_o(cmd_v), .cmd_ready_i(cmd_ready),
      .resp_i(resp), .resp_v_i(resp_v), .resp_ready_o(resp_ready),
      .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_ready_i(req_resp_ready),
      .outstanding_o(outstanding), .err_o(err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int sb[$];
   logic [W-1:0] cmd_data [N] = '{16'hA000, 16'hB001};

   typedef struct {
      logic [1:0]  v;
      logic        crdy;
      logic        rv;
      logic [1:0]  rrdy;
      logic        exp_cmd_v;
      logic [1:0]  exp_cready;
      logic [15:0] exp_cmd;
      logic        exp_rready;
      logic [1:0]  exp_rv;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic crdy, input logic rv,
                       input logic [15:0] rdata, input int eg);
      int id;
      @(posedge clk); #1;
      req_cmd_v = v; cmd_ready = crdy; resp_v = rv; resp = rdata;
      @(negedge clk);
      if (rv) begin
         if (sb.size() == 0) begin
            chk("spur_ready", 64'(resp_ready), 64'(1));
            chk("spur_resp_v", 64'(req_resp_v), 64'(0));
         end else begin
            id = sb.pop_front();
            chk("resp_v_onehot", 64'(req_resp_v), 64'(1) << id);
            chk("resp_data", 64'(req_resp), 64'(rdata));
            chk("resp_ready", 64'(resp_ready), 64'(1));
         end
      end
      if (eg >= 0) begin
         chk("cmd_v", 64'(cmd_v), 64'(1));
         chk("cmd_data", 64'(cmd), 64'(cmd_data[eg]));
         chk("cmd_ready_onehot", 64'(req_cmd_ready), crdy ? (64'(1) << eg) : 64'(0));
         if (crdy) sb.push_back(eg);
      end else begin
         chk("no_cmd_v", 64'(cmd_v), 64'(0));
         chk("no_cmd_ready", 64'(req_cmd_ready), 64'(0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      req_cmd        = {cmd_data[1], cmd_data[0]};
      req_resp_ready = 2'b11;
      // Outputs must stay low while reset is held even with active inputs.
      reset_n   = 1'b0;
      req_cmd_v = 2'b11; cmd_ready = 1'b1; resp_v = 1'b1; resp = 16'h1234;
      #3;
      chk("rst_cmd_v", 64'(cmd_v), 64'(0));
      chk("rst_cmd_ready", 64'(req_cmd_ready), 64'(0));
      chk("rst_resp_ready", 64'(resp_ready), 64'(0));
      chk("rst_resp_v", 64'(req_resp_v), 64'(0));
      chk("rst_outstanding", 64'(outstanding), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      req_cmd_v = '0; cmd_ready = 1'b0; resp_v = 1'b0; resp = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Idle state (empty, pointer 0): each vector is removed before the next edge.
      vecs.push_back('{2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 16'h0000, 1'b0, 2'b00});
      vecs.push_back('{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 16'hA000, 1'b0, 2'b00});
      vecs.push_back('{2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 16'hB001, 1'b0, 2'b00});
      vecs.push_back('{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 16'hA000, 1'b0, 2'b00});
      vecs.push_back('{2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 16'hA000, 1'b0, 2'b00});
      vecs.push_back('{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 16'h0000, 1'b1, 2'b00});
      vecs.push_back('{2'b10, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 16'hB001, 1'b1, 2'b00});
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req_cmd_v = vecs[i].v; cmd_ready = vecs[i].crdy;
         resp_v = vecs[i].rv; req_resp_ready = vecs[i].rrdy;
         #2;
         chk($sformatf("vec%0d_cmd_v", i), 64'(cmd_v), 64'(vecs[i].exp_cmd_v));
         chk($sformatf("vec%0d_cmd_ready", i), 64'(req_cmd_ready), 64'(vecs[i].exp_cready));
         if (vecs[i].exp_cmd_v)
            chk($sformatf("vec%0d_cmd", i), 64'(cmd), 64'(vecs[i].exp_cmd));
         chk($sformatf("vec%0d_resp_ready", i), 64'(resp_ready), 64'(vecs[i].exp_rready));
         chk($sformatf("vec%0d_resp_v", i), 64'(req_resp_v), 64'(vecs[i].exp_rv));
         req_cmd_v = '0; cmd_ready = 1'b0; resp_v = 1'b0; req_resp_ready = 2'b11;
      end
      chk("idle_err", 64'(err), 64'(0));
      chk("idle_outstanding", 64'(outstanding), 64'(0));

      // Round robin with responses two cycles behind their commands.
      step(2'b11, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b11, 1'b1, 1'b0, 16'h0000, 1);
      step(2'b11, 1'b1, 1'b1, 16'h5000, 0);
      step(2'b11, 1'b1, 1'b1, 16'h5001, 1);
      chk("rr_outstanding_mid", 64'(outstanding), 64'(2));
      step(2'b00, 1'b1, 1'b1, 16'h5002, -1);
      step(2'b00, 1'b1, 1'b1, 16'h5003, -1);
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("rr_outstanding_end", 64'(outstanding), 64'(0));
      chk("rr_err", 64'(err), 64'(0));

      // Link stall: grant and data hold, pointer does not move.
      for (int i = 0; i < 5; i++) step(2'b11, 1'b0, 1'b0, 16'h0000, 0);
      step(2'b11, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b00, 1'b0, 1'b1, 16'h5100, -1);

      // Fill to capacity, then a pop in the same cycle as a pending command.
      step(2'b11, 1'b1, 1'b0, 16'h0000, 1);
      step(2'b11, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b11, 1'b1, 1'b0, 16'h0000, 1);
      step(2'b11, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b11, 1'b1, 1'b0, 16'h0000, -1);
      chk("full_outstanding", 64'(outstanding), 64'(4));
      step(2'b11, 1'b1, 1'b1, 16'h5200, -1);
      chk("full_pop_cycle", 64'(outstanding), 64'(4));
      step(2'b11, 1'b1, 1'b0, 16'h0000, 1);
      chk("after_pop", 64'(outstanding), 64'(3));
      step(2'b00, 1'b1, 1'b1, 16'h5201, -1);
      chk("refilled", 64'(outstanding), 64'(4));
      step(2'b00, 1'b1, 1'b1, 16'h5202, -1);
      step(2'b00, 1'b1, 1'b1, 16'h5203, -1);
      step(2'b00, 1'b1, 1'b1, 16'h5204, -1);
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("drained", 64'(outstanding), 64'(0));

      // Response with nothing outstanding.
      step(2'b00, 1'b0, 1'b1, 16'hDEAD, -1);
      chk("spur_data", 64'(req_resp), 64'(16'hDEAD));
      chk("spur_err_same_cycle", 64'(err), 64'(0));
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("spur_err_set", 64'(err), 64'(1));
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("spur_err_sticky", 64'(err), 64'(1));

      // Asynchronous reset with three commands in flight.
      step(2'b01, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b01, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b01, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("pre_reset_outstanding", 64'(outstanding), 64'(3));
      @(posedge clk); #1;
      req_cmd_v = 2'b11; cmd_ready = 1'b1; resp_v = 1'b1; resp = 16'h7777;
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_cmd_v", 64'(cmd_v), 64'(0));
      chk("mid_rst_cmd_ready", 64'(req_cmd_ready), 64'(0));
      chk("mid_rst_resp_ready", 64'(resp_ready), 64'(0));
      chk("mid_rst_resp_v", 64'(req_resp_v), 64'(0));
      chk("mid_rst_outstanding", 64'(outstanding), 64'(0));
      chk("mid_rst_err", 64'(err), 64'(0));
      sb.delete();
      @(negedge clk);
      req_cmd_v = '0; cmd_ready = 1'b0; resp_v = 1'b0; resp = '0;
      #1 reset_n = 1'b1;
      step(2'b11, 1'b1, 1'b0, 16'h0000, 0);
      step(2'b00, 1'b0, 1'b1, 16'h5300, -1);
      step(2'b00, 1'b0, 1'b0, 16'h0000, -1);
      chk("post_rst_outstanding", 64'(outstanding), 64'(0));
      chk("post_rst_err", 64'(err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_io_cmd_arbiter.md
Name: bp_io_cmd_arbiter

Overview:
Shares the single host I/O command/response channel between several requesters, for example the NBF loader and a second host agent. Command acceptance is round-robin. Each accepted command's requester ID is recorded in an in-order tracking FIFO, and responses are steered back to the requester that issued the matching command. The block sits between the requesters and the CCE-to-mem link toward the chip. Single-beat messages only; the downstream returns responses in command order.

Parameters:
num_req_p, 2, number of requesters (>=2).
msg_width_p, 256, width of one command/response message.
max_outstanding_p, 4, tracking FIFO depth = max commands in flight (power of 2).

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous active-low reset.
req_cmd_i  in  num_req_p*msg_width_p  per-requester command, requester i at slice i.
req_cmd_v_i  in  num_req_p  per-requester command valid.
req_cmd_ready_o  out  num_req_p  per-requester command ready.
cmd_o  out  msg_width_p  granted command toward the link.
cmd_v_o  out  1  command valid toward the link.
cmd_ready_i  in  1  link ready.
resp_i  in  msg_width_p  response from the link.
resp_v_i  in  1  response valid.
resp_ready_o  out  1  response ready toward the link.
req_resp_o  out  msg_width_p  response broadcast to all requesters.
req_resp_v_o  out  num_req_p  one-hot response valid.
req_resp_ready_i  in  num_req_p  per-requester response ready.
outstanding_o  out  clog2(max_outstanding_p+1)  commands in flight.
err_o  out  1  sticky error: response arrived with no command outstanding.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - FIFO empty; rr pointer = 0; outstanding_o = 0; err_o = 0.
  - All ready/valid outputs are 0 while reset is asserted.
  - Reset mid-transaction discards all tracking state; in-flight responses arriving after reset are treated as unexpected.
- Arbitration (combinational grant, registered pointer):
  - eligible = req_cmd_v_i when FIFO not full, else 0.
  - The grant is the first eligible index at or after the rr pointer, searching upward with wrap.
  - cmd_o = req_cmd_i slice of the granted requester.
  - cmd_v_o = |eligible.
  - req_cmd_ready_o[g] = cmd_ready_i & ~full; all other bits are 0.
  - Grant must not depend on cmd_ready_i, so there is no valid→ready combinational loop on the link side.
- Command handshake (cmd_v_o & cmd_ready_i):
  - Push the grant ID into the FIFO.
  - Set the rr pointer to (g+1) mod num_req_p.
  - The pointer holds when no handshake occurs, so a stalled grant stays stable (valid/data stable until accepted).
- Full: no grant is issued when the FIFO is full, even if a response dequeues in the same cycle. Grant resumes the cycle after a pop.
- Response routing:
  - head = FIFO head ID.
  - req_resp_o = resp_i.
  - req_resp_v_o[head] = resp_v_i & ~empty; all other bits are 0.
  - resp_ready_o = req_resp_ready_i[head] & ~empty.
  - On handshake, pop the FIFO. Latency is 0 cycles (combinational pass-through).
- Empty with resp_v_i = 1:
  - resp_ready_o = 1 (drain the spurious response); no req_resp_v_o is asserted.
  - err_o is set and stays set until reset.
- Simultaneous push and pop (only when not full): outstanding_o is unchanged and FIFO pointers both advance.
- outstanding_o = pushes − pops.
  - Wraps never occur; overflow and underflow are prevented by the full/empty gating.
  - Write and read pointers carry one extra bit for full detection.
- Requester IDs are stored as clog2(num_req_p) bits.

Test Plan:
- Reset release, all inputs 0 → all outputs 0; outstanding_o=0; err_o=0; after one req0 command and response, err_o still 0.
- req0 and req1 both valid continuously, cmd_ready_i=1, responses returned 2 cycles later → grant sequence 0,1,0,1; each response asserts req_resp_v_o matching its command's issuer (0b01, 0b10, 0b01, 0b10).
- cmd_ready_i=0 for 5 cycles with req0 and req1 valid → grant stays on the same requester; cmd_o stable; rr pointer unchanged.
- max_outstanding_p=4: issue 4 commands with no responses → outstanding_o=4; cmd_v_o=0. One response the same cycle a 5th command is valid → no grant that cycle, grant next cycle; outstanding_o goes 4→3→4.
- Response with FIFO empty (resp_i=0xDEAD) → resp_ready_o=1, req_resp_v_o=0, err_o=1 from the next cycle and sticky.
- Drop reset_n_i mid-flight with outstanding_o=3 → outputs go to 0 immediately (asynchronous). After release, outstanding_o=0 and the first grant goes to requester 0.
